// File: rtl/rr_arb_rsp_router.sv
// Return path for the round-robin arbitration tree: forwards the arbitrated request to a
// single slave and routes the slave's in-order responses back to the originating master.
module rr_arb_rsp_router #(
    parameter  int unsigned NumIn     = 64,
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned RspWidth  = 32,
    parameter  int unsigned MaxTrans  = 4,
    localparam int unsigned IdxW      = (NumIn > 1) ? $clog2(NumIn) : 1,
    localparam int unsigned CntW      = $clog2(MaxTrans + 1),
    localparam int unsigned PtrW      = (MaxTrans > 1) ? $clog2(MaxTrans) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 arb_req_i,
    output logic                 arb_gnt_o,
    input  logic [DataWidth-1:0] arb_data_i,
    input  logic [IdxW-1:0]      arb_idx_i,
    output logic                 slv_req_o,
    input  logic                 slv_gnt_i,
    output logic [DataWidth-1:0] slv_data_o,
    input  logic                 slv_rsp_valid_i,
    output logic                 slv_rsp_ready_o,
    input  logic [RspWidth-1:0]  slv_rsp_data_i,
    output logic [NumIn-1:0]     mst_rsp_valid_o,
    input  logic [NumIn-1:0]     mst_rsp_ready_i,
    output logic [RspWidth-1:0]  mst_rsp_data_o,
    output logic [CntW-1:0]      outstanding_o,
    output logic                 idle_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic            full, empty, push, pop;
    logic [IdxW-1:0] head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxTrans - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Full is judged on the registered count, so a same-cycle pop never re-opens the grant.
    assign full  = (cnt_q == CntW'(MaxTrans));
    assign empty = (cnt_q == '0);

    assign slv_req_o  = arb_req_i & ~full;
    assign arb_gnt_o  = slv_gnt_i & ~full;
    assign slv_data_o = arb_data_i;
    assign push       = arb_req_i & arb_gnt_o;

    assign slv_rsp_ready_o = mst_rsp_ready_i[head] & ~empty;
    assign mst_rsp_data_o  = slv_rsp_data_i;
    assign pop             = slv_rsp_valid_i & slv_rsp_ready_o;

    assign outstanding_o = cnt_q;
    assign idle_o        = empty;

    always_comb begin
        mst_rsp_valid_o = '0;
        if (slv_rsp_valid_i && !empty) begin
            mst_rsp_valid_o[head] = 1'b1;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            cnt_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            if (push && !pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // ID storage holds no reset: the count alone decides which entries are live.
    if (NumIn > 1) begin : g_id_fifo
        logic [IdxW-1:0] fifo_q [MaxTrans];
        logic [IdxW-1:0] fifo_d [MaxTrans];

        always_comb begin
            fifo_d = fifo_q;
            if (push && !flush_i) begin
                fifo_d[wptr_q] = arb_idx_i;
            end
        end

        always_ff @(posedge clk_i) begin
            fifo_q <= fifo_d;
        end

        assign head = fifo_q[rptr_q];
    end else begin : g_single_master
        assign head = '0;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            a_rsp_onehot0: assert ($onehot0(mst_rsp_valid_o));
            a_cnt_bound:   assert (cnt_q <= CntW'(MaxTrans));
            if (push && NumIn > 1) begin
                a_idx_range: assert (32'(arb_idx_i) < NumIn);
            end
        end
    end
`endif

endmodule
